// File: rtl/lfsr_period_checker_pkg.sv
// rtl/lfsr_period_checker_pkg.sv - shared types, codes and length-mask helper for the LFSR period checker
//
// Purpose : state encodings, fault codes and the n -> mask helper shared by
//           lfsr_len_mask, lfsr_period_checker and the top-level output mux.
// Contents: state_e (ST_IDLE..ST_FAULT, 3-bit), FC_* fault codes (2-bit),
//           LEN_W / MASK_W widths, len_to_mask().
package lfsr_period_checker_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_COUNT = 3'd2,
    ST_DONE  = 3'd3,
    ST_FAULT = 3'd4
  } state_e;

  localparam logic [1:0] FC_INVALID = 2'd0;
  localparam logic [1:0] FC_ZERO    = 2'd1;
  localparam logic [1:0] FC_CFG     = 2'd2;
  localparam logic [1:0] FC_TIMEOUT = 2'd3;

  // lfsr_length is 3 bits, so n <= 7 and the mask always fits in 8 bits.
  localparam int LEN_W  = 3;
  localparam int MASK_W = 8;

  // (1 << n) - 1: low n bits set; n = 0 yields an empty mask.
  function automatic logic [MASK_W-1:0] len_to_mask(input logic [LEN_W-1:0] len);
    return (MASK_W'(1) << len) - MASK_W'(1);
  endfunction

endpackage

// File: rtl/lfsr_len_mask.sv
// rtl/lfsr_len_mask.sv - combinational LFSR length to state mask and expected maximal period
//
// Purpose : converts the active LFSR length n into the state mask applied to
//           lfsr_value and the period a maximal-length sequence would have.
// Ports   : len        in  LEN_W  active LFSR length n
//           mask       out WIDTH  (1<<n)-1, selects the effective state bits
//           max_period out WIDTH  2^n-1, expected period of a maximal sequence
module lfsr_len_mask
  import lfsr_period_checker_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [LEN_W-1:0] len,
  output logic [WIDTH-1:0] mask,
  output logic [WIDTH-1:0] max_period
);

  logic [MASK_W-1:0] full_mask;

  assign full_mask  = len_to_mask(len);
  assign mask       = WIDTH'(full_mask);
  // 2^n-1 has the same bit pattern as the n-bit mask; kept as a separate
  // port because the top-level mux consumes it as a count, not a mask.
  assign max_period = WIDTH'(full_mask);

endmodule

// File: rtl/lfsr_period_checker.sv
// rtl/lfsr_period_checker.sv - measures the period of an LFSR sequence and classifies faults
//
// Purpose : arms on start, captures the masked LFSR state as seed, counts
//           advances until the seed recurs, flags maximal-length sequences and
//           reports INVALID / ZERO / CFG / TIMEOUT faults.
// Ports   : clk, rst_n (async, active-low)
//           step_en, lfsr_value[WIDTH], lfsr_valid, lfsr_length[3]  LFSR sample
//           start, clear                                           control
//           busy, done, fault, fault_code[2], period[WIDTH], maximal results
//           signature[WIDTH] (only with LFSR_CHK_SIGNATURE_EN)     rolling signature
// Config  : define LFSR_CHK_SIGNATURE_EN to add the signature output.
module lfsr_period_checker
  import lfsr_period_checker_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step_en,
  input  logic [WIDTH-1:0] lfsr_value,
  input  logic             lfsr_valid,
  input  logic [LEN_W-1:0] lfsr_length,
  input  logic             start,
  input  logic             clear,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic [1:0]       fault_code,
  output logic [WIDTH-1:0] period,
  output logic             maximal
`ifdef LFSR_CHK_SIGNATURE_EN
  ,
  output logic [WIDTH-1:0] signature
`endif
);

  localparam logic [WIDTH-1:0] TIMEOUT_W = WIDTH'(TIMEOUT);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] cfg_len_q, cfg_len_d;
  logic [WIDTH-1:0] seed_q, seed_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             fault_q, fault_d;
  logic [1:0]       fault_code_q, fault_code_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             maximal_q, maximal_d;
`ifdef LFSR_CHK_SIGNATURE_EN
  logic [WIDTH-1:0] sig_q, sig_d;
`endif

  logic [WIDTH-1:0] state_mask;
  logic [WIDTH-1:0] max_period;
  logic [WIDTH-1:0] ms;
  logic [WIDTH-1:0] cnt_next;
  logic             fault_go;
  logic [1:0]       fault_sel;

  // Mask from the latched length: while measuring, any difference between
  // lfsr_length and cfg_len is already a CFG fault, so both give the same ms.
  lfsr_len_mask #(.WIDTH(WIDTH)) u_len_mask (
    .len        (cfg_len_q),
    .mask       (state_mask),
    .max_period (max_period)
  );

  always_comb begin
    state_d      = state_q;
    cfg_len_d    = cfg_len_q;
    seed_d       = seed_q;
    cnt_d        = cnt_q;
    done_d       = done_q;
    fault_d      = fault_q;
    fault_code_d = fault_code_q;
    period_d     = period_q;
    maximal_d    = maximal_q;
`ifdef LFSR_CHK_SIGNATURE_EN
    sig_d        = sig_q;
`endif
    ms        = lfsr_value & state_mask;
    cnt_next  = cnt_q + WIDTH'(1);
    fault_go  = 1'b0;
    fault_sel = FC_INVALID;

    if (clear) begin
      state_d      = ST_IDLE;
      done_d       = 1'b0;
      fault_d      = 1'b0;
      fault_code_d = FC_INVALID;
      period_d     = '0;
      maximal_d    = 1'b0;
`ifdef LFSR_CHK_SIGNATURE_EN
      sig_d        = '0;
`endif
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE, ST_FAULT: begin
          if (start) begin
            state_d      = ST_ARM;
            cfg_len_d    = lfsr_length;
            done_d       = 1'b0;
            fault_d      = 1'b0;
            fault_code_d = FC_INVALID;
            period_d     = '0;
            maximal_d    = 1'b0;
`ifdef LFSR_CHK_SIGNATURE_EN
            sig_d        = '0;
`endif
          end
        end
        ST_ARM: begin
          if (lfsr_length != cfg_len_q) begin
            fault_go  = 1'b1;
            fault_sel = FC_CFG;
          end else if (step_en) begin
            if (!lfsr_valid) begin
              fault_go  = 1'b1;
              fault_sel = FC_INVALID;
            end else if (ms == '0) begin
              fault_go  = 1'b1;
              fault_sel = FC_ZERO;
            end else begin
              seed_d  = ms;
              cnt_d   = '0;
              state_d = ST_COUNT;
            end
          end
        end
        ST_COUNT: begin
          if (lfsr_length != cfg_len_q) begin
            fault_go  = 1'b1;
            fault_sel = FC_CFG;
          end else if (step_en) begin
            if (!lfsr_valid) begin
              fault_go  = 1'b1;
              fault_sel = FC_INVALID;
            end else if (ms == '0) begin
              fault_go  = 1'b1;
              fault_sel = FC_ZERO;
            end else begin
`ifdef LFSR_CHK_SIGNATURE_EN
              sig_d = {sig_q[WIDTH-2:0], sig_q[WIDTH-1]} ^ ms;
`endif
              // Recurrence wins over timeout so a full-length sequence whose
              // period equals TIMEOUT still completes.
              if (ms == seed_q) begin
                state_d   = ST_DONE;
                done_d    = 1'b1;
                period_d  = cnt_next;
                maximal_d = (cnt_next == max_period);
              end else if (cnt_next == TIMEOUT_W) begin
                fault_go  = 1'b1;
                fault_sel = FC_TIMEOUT;
              end else begin
                cnt_d = cnt_next;
              end
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase

      if (fault_go) begin
        state_d      = ST_FAULT;
        fault_d      = 1'b1;
        fault_code_d = fault_sel;
      end
    end

    busy_d = (state_d == ST_ARM) || (state_d == ST_COUNT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cfg_len_q    <= '0;
      seed_q       <= '0;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fault_q      <= 1'b0;
      fault_code_q <= FC_INVALID;
      period_q     <= '0;
      maximal_q    <= 1'b0;
`ifdef LFSR_CHK_SIGNATURE_EN
      sig_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cfg_len_q    <= cfg_len_d;
      seed_q       <= seed_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      fault_q      <= fault_d;
      fault_code_q <= fault_code_d;
      period_q     <= period_d;
      maximal_q    <= maximal_d;
`ifdef LFSR_CHK_SIGNATURE_EN
      sig_q        <= sig_d;
`endif
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign fault      = fault_q;
  assign fault_code = fault_code_q;
  assign period     = period_q;
  assign maximal    = maximal_q;
`ifdef LFSR_CHK_SIGNATURE_EN
  assign signature  = sig_q;
`endif

endmodule

// File: doc/lfsr_period_checker.md
Name: lfsr_period_checker

Overview:
Downstream consumer of the Fibonacci LFSR stage. It samples the LFSR value/valid stream once per LFSR advance and measures the sequence period, which is the number of advances until the captured seed state recurs. It flags maximal-length sequences and classifies faults: invalid output, all-zero lock-up, configuration change and timeout. Results feed the top-level output mux for on-silicon self-test of the tap tables.

Parameters:
- WIDTH, 8, LFSR value width; also the period counter width.
- TIMEOUT, 255, number of advances in COUNT without seed recurrence before FAULT_TIMEOUT; must be ≤ 2^WIDTH-1.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- step_en  in  1  one-cycle strobe: LFSR advanced this cycle and sample inputs are valid
- lfsr_value  in  WIDTH  current LFSR register
- lfsr_valid  in  1  LFSR valid flag
- lfsr_length  in  3  active LFSR length n; effective state = lfsr_value[n-1:0]
- start  in  1  pulse: arm a measurement
- clear  in  1  synchronous abort/clear to IDLE; priority over start
- busy  out  1  high in ARM or COUNT
- done  out  1  high in DONE; held until clear or start
- fault  out  1  high in FAULT; held until clear or start
- fault_code  out  2  0=INVALID, 1=ZERO, 2=CFG, 3=TIMEOUT; meaningful only while fault=1
- period  out  WIDTH  measured period; valid while done=1
- maximal  out  1  done && period == 2^n-1

Behaviour:
- Reset: state=IDLE. All outputs 0: busy, done, fault, fault_code, period, maximal.
- Masked state ms = lfsr_value & ((1<<n)-1). Expected maximal period = (1<<n)-1, computed WIDTH bits wide.
- States: IDLE, ARM, COUNT, DONE, FAULT. All outputs are registered.
- IDLE / DONE / FAULT:
  - start=1 → ARM. Clears done, fault, period, maximal. Latches cfg_len = lfsr_length.
- ARM, on step_en:
  - lfsr_valid=0 → FAULT/INVALID.
  - ms==0 → FAULT/ZERO.
  - Otherwise seed ← ms, cnt ← 0, → COUNT.
- COUNT, on step_en:
  - cnt_next = cnt+1.
  - Checks in priority order:
    1. lfsr_valid=0 → FAULT/INVALID
    2. ms==0 → FAULT/ZERO
    3. ms==seed → DONE, period ← cnt_next
    4. cnt_next==TIMEOUT → FAULT/TIMEOUT
    5. else cnt ← cnt_next
- Any state except IDLE/DONE/FAULT: lfsr_length != cfg_len → FAULT/CFG in the same cycle. This check takes precedence over step_en handling.
- step_en=0: no state change except the CFG check and clear.
- start while busy: ignored.
- clear=1: → IDLE from any state, all outputs as at reset, same cycle as start or not.
- Latency: done asserts the cycle after the step_en that presents the recurring seed.
- Counter never wraps, because TIMEOUT bounds it.
- rst_n asserted mid-measurement: immediate return to reset values. No partial result is retained.

Optional Feature:
Macro LFSR_CHK_SIGNATURE_EN.
- With the macro: adds output signature[WIDTH-1:0] (reset 0, cleared on start).
  - In COUNT, on every accepted step_en: signature ← {signature[WIDTH-2:0], signature[WIDTH-1]} ^ ms.
  - Frozen in DONE/FAULT.
- Without the macro: port and logic absent. All other behaviour is identical.

Decomposition:
- Shared package/header holds:
  - state encodings ST_IDLE..ST_FAULT (3-bit)
  - fault codes FC_INVALID/FC_ZERO/FC_CFG/FC_TIMEOUT
  - length-to-mask function
- One sub-module, lfsr_len_mask: combinational n → state mask and expected maximal period. Reused by the top-level mux.

Test Plan:
- n=3, 2-tap (mask 110), seed 001, start then 7 step_en: sequence 001,010,101,011,111,110,100,001 → done=1, period=7, maximal=1, busy=0.
- n=4, 2-tap mask 1100, seed 0001 → period=15, maximal=1. Then start again → done clears; re-measure → 15.
- n=0 (LFSR outputs value 0, valid 0), start + step_en → fault=1, fault_code=0 (INVALID), done=0.
- Present ms=0 with valid=1 in ARM → fault_code=1 (ZERO). Repeat in COUNT after 3 steps → fault_code=1.
- Change lfsr_length 3→5 at COUNT step 2 → fault=1, fault_code=2 the next cycle. Set TIMEOUT=4 with n=3 → fault_code=3 after the 4th step.
- clear or rst_n mid-COUNT → all outputs 0, state IDLE. With LFSR_CHK_SIGNATURE_EN, n=3 run → signature matches the bench model after 7 steps.
